// File: rtl/system_0_sysid_ext_if.sv
// Avalon-MM bus bundle for system_0_sysid_ext: word address, one-cycle read/write
// strobes, byte-enabled write data and registered read data with readdatavalid.
// The master drives strobes; the slave returns readdatavalid exactly one cycle
// after an accepted read. There is no waitrequest: every strobe is accepted.
interface system_0_sysid_ext_if #(
   parameter int ADDR_W = 3
);
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [3:0]        byteenable;
   logic [31:0]       readdata;
   logic              readdatavalid;

   modport master (
      output address, read, write, writedata, byteenable,
      input  readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output readdata, readdatavalid
   );
endinterface

// File: rtl/system_0_sysid_ext.sv
// system_0_sysid_ext: system-ID slave with build ID, timestamp, scratch word,
// capability word and (optionally) a prescaled free-running uptime counter.
// Optional uptime logic is built when the macro SYSID_EXT_UPTIME_EN is defined;
// without it words 2, 3 and 5 read 0 and CTRL writes are ignored.
// Handshake: read sampled at edge N returns readdata/readdatavalid after edge N;
// readdata holds between reads; a simultaneous write is dropped in favour of the read.
module system_0_sysid_ext #(
   parameter logic [31:0] ID_VALUE  = 32'h6930_4ABB,
   parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
   parameter int          CNT_W     = 64,
   parameter int          PRESCALE  = 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   system_0_sysid_ext_if.slave  bus
);

`ifdef SYSID_EXT_UPTIME_EN
   localparam logic UPTIME_PRESENT = 1'b1;
`else
   localparam logic UPTIME_PRESENT = 1'b0;
`endif

   localparam logic [31:0] CAPS_WORD = {8'(PRESCALE > 1), 8'(CNT_W), 15'd0, UPTIME_PRESENT};

   logic [2:0]  word;
   logic        rd_en;
   logic        wr_en;
   logic        unused_addr;

   // Upper address bits only alias; the word is always address[2:0].
   assign word        = bus.address[2:0];
   assign unused_addr = ^bus.address;
   assign rd_en       = bus.read;
   assign wr_en       = bus.write & ~bus.read;

   logic [31:0] scratch_q, scratch_d;
   logic [31:0] readdata_q, readdata_d;
   logic        rdvalid_q, rdvalid_d;
   logic [31:0] lo_word, hi_word, ctrl_word;

`ifdef SYSID_EXT_UPTIME_EN
   localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

   logic                run_q, run_d;
   logic [15:0]         presc_q, presc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-33:0]   shadow_q, shadow_d;
   logic                ctrl_wr, clr, tick;

   // Uptime next state: CLR beats a same-cycle tick; a lo read snapshots the
   // pre-increment upper counter bits into the shadow.
   always_comb begin
      ctrl_wr  = wr_en && (word == 3'd5) && bus.byteenable[0];
      clr      = ctrl_wr && bus.writedata[0];
      tick     = run_q && (presc_q == PRESC_LAST);
      run_d    = ctrl_wr ? bus.writedata[1] : run_q;
      presc_d  = presc_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      if (clr) begin
         presc_d = '0;
         cnt_d   = '0;
      end else if (run_q) begin
         presc_d = tick ? 16'd0 : presc_q + 16'd1;
         if (tick) cnt_d = cnt_q + CNT_W'(1);
      end
      if (rd_en && (word == 3'd2)) shadow_d = cnt_q[CNT_W-1:32];
   end

   // Uptime register file.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         run_q    <= 1'b1;
         presc_q  <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
      end else begin
         run_q    <= run_d;
         presc_q  <= presc_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
      end
   end

   // Read views of the uptime words; hi is the shadow zero-extended.
   always_comb begin
      lo_word   = cnt_q[31:0];
      hi_word   = '0;
      hi_word[CNT_W-33:0] = shadow_q;
      ctrl_word = {30'd0, run_q, 1'b0};
   end
`else
   // No uptime logic in this build: its words read as zero.
   always_comb begin
      lo_word   = '0;
      hi_word   = '0;
      ctrl_word = '0;
   end
`endif

   // Scratch byte-lane merge on an accepted write to word 4.
   always_comb begin
      scratch_d = scratch_q;
      if (wr_en && (word == 3'd4)) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.byteenable[b]) scratch_d[8*b +: 8] = bus.writedata[8*b +: 8];
         end
      end
   end

   // Read mux; readdata only changes on an accepted read.
   always_comb begin
      readdata_d = readdata_q;
      rdvalid_d  = rd_en;
      if (rd_en) begin
         case (word)
            3'd0:    readdata_d = ID_VALUE;
            3'd1:    readdata_d = TIMESTAMP;
            3'd2:    readdata_d = lo_word;
            3'd3:    readdata_d = hi_word;
            3'd4:    readdata_d = scratch_q;
            3'd5:    readdata_d = ctrl_word;
            3'd6:    readdata_d = CAPS_WORD;
            default: readdata_d = '0;
         endcase
      end
   end

   // Bus-side registers; async reset drops readdatavalid immediately.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scratch_q  <= '0;
         readdata_q <= '0;
         rdvalid_q  <= 1'b0;
      end else begin
         scratch_q  <= scratch_d;
         readdata_q <= readdata_d;
         rdvalid_q  <= rdvalid_d;
      end
   end

   assign bus.readdata      = readdata_q;
   assign bus.readdatavalid = rdvalid_q;

endmodule

// File: tb/tb_system_0_sysid_ext.sv
// Bench for system_0_sysid_ext: directed steps in one initial block, expected
// read data queued at issue time and compared when readdatavalid returns.
// Uptime steps are compiled only when SYSID_EXT_UPTIME_EN is defined.
module tb_system_0_sysid_ext;
   localparam int          ADDR_W   = 4;
   localparam int          CNT_W    = 64;
   localparam int          PRESCALE = 4;
   localparam logic [31:0] ID_EXP   = 32'h6930_4ABB;
   localparam logic [31:0] TS_EXP   = 32'h2024_0611;
`ifdef SYSID_EXT_UPTIME_EN
   // {8'd1 (PRESCALE>1), 8'd64, 15'd0, 1'b1}
   localparam logic [31:0] CAPS_EXP = 32'h0140_0001;
   localparam logic [31:0] CTRL_RST = 32'h0000_0002;
`else
   localparam logic [31:0] CAPS_EXP = 32'h0140_0000;
   localparam logic [31:0] CTRL_RST = 32'h0000_0000;
`endif

   // ---------------- clock / reset ----------------
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   system_0_sysid_ext_if #(.ADDR_W(ADDR_W)) sbus ();

   system_0_sysid_ext #(
      .ID_VALUE (ID_EXP),
      .TIMESTAMP(TS_EXP),
      .CNT_W    (CNT_W),
      .PRESCALE (PRESCALE)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (sbus)
   );

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   string       tag_q[$];
   int          cmp_cnt = 0;
   int          err_cnt = 0;
   logic        rd_prev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // A read accepted at the previous edge must show readdatavalid now.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rd_prev <= 1'b0;
      else          rd_prev <= sbus.read;
   end

   always @(negedge clock) begin
      logic [31:0] e;
      string       t;
      check("rdvalid", {31'd0, sbus.readdatavalid}, {31'd0, rd_prev});
      if (sbus.readdatavalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            cmp_cnt++;
            err_cnt++;
            $error("FAIL unexpected_rdvalid: observed readdatavalid=1 expected no pending read");
         end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, sbus.readdata, e);
         end
      end
   end

   // ---------------- driver tasks (start and end on a falling edge) ----------------
   task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      sbus.address    = a;
      sbus.write      = 1'b1;
      sbus.writedata  = d;
      sbus.byteenable = be;
      @(negedge clock);
      sbus.write      = 1'b0;
      sbus.byteenable = 4'h0;
   endtask

   task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
      sbus.address = a;
      sbus.read    = 1'b1;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge clock);
      sbus.read    = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "bench timed out");
   end

   // ---------------- directed steps ----------------
   initial begin
      logic [31:0] rnd;
      sbus.address    = '0;
      sbus.read       = 1'b0;
      sbus.write      = 1'b0;
      sbus.writedata  = '0;
      sbus.byteenable = 4'h0;
      repeat (3) @(negedge clock);
      check("rst_readdata", sbus.readdata, 32'h0);
      check("rst_rdvalid", {31'd0, sbus.readdatavalid}, 32'h0);
      reset_n = 1'b1;
      @(negedge clock);

      // T1: identity words back-to-back, then readdata must hold.
      bus_read(4'd0, ID_EXP,   "t1_id");
      bus_read(4'd1, TS_EXP,   "t1_ts");
      bus_read(4'd6, CAPS_EXP, "t1_caps");
      @(negedge clock);
      check("hold_readdata", sbus.readdata, CAPS_EXP);
      bus_read(4'd14, CAPS_EXP, "alias_caps");
      bus_read(4'd7,  32'h0,    "word7");
      bus_read(4'd4,  32'h0,    "scratch_rst");
      bus_read(4'd5,  CTRL_RST, "ctrl_rst");

      // T2: byte-enabled scratch writes.
      bus_write(4'd4, 32'hDEAD_BEEF, 4'b0101);
      bus_read(4'd4, 32'h00AD_00EF, "t2_be0101");
      bus_write(4'd4, 32'h1234_5678, 4'b1010);
      bus_read(4'd4, 32'h12AD_56EF, "t2_be1010");
      rnd = $urandom_range(32'h7FFF_FFFF, 0);
      bus_write(4'd12, rnd, 4'hF);
      bus_read(4'd4, rnd, "scratch_alias_rand");

      // Read and write together: read served with old data, write dropped.
      sbus.address    = 4'd4;
      sbus.read       = 1'b1;
      sbus.write      = 1'b1;
      sbus.writedata  = ~rnd;
      sbus.byteenable = 4'hF;
      exp_q.push_back(rnd);
      tag_q.push_back("rw_collide_read");
      @(negedge clock);
      sbus.read       = 1'b0;
      sbus.write      = 1'b0;
      sbus.byteenable = 4'h0;
      bus_read(4'd4, rnd, "rw_collide_dropped");

      // Writes to read-only words are ignored.
      bus_write(4'd0, 32'h0, 4'hF);
      bus_write(4'd6, 32'h0, 4'hF);
      bus_read(4'd0, ID_EXP,   "ro_id");
      bus_read(4'd6, CAPS_EXP, "ro_caps");

`ifdef SYSID_EXT_UPTIME_EN
      // T3: CLR+RUN at edge E0; read sampled at E41 sees ticks at E4..E40 = 10.
      bus_write(4'd5, 32'h3, 4'hF);
      repeat (40) @(negedge clock);
      bus_read(4'd2, 32'd10, "t3_lo_after_40");
      bus_write(4'd5, 32'h0, 4'hF);
      repeat (100) @(negedge clock);
      bus_read(4'd2, 32'd10, "t3_frozen");
      bus_read(4'd5, 32'h0,  "t3_ctrl_run0");
      bus_read(4'd3, 32'h0,  "t3_hi");

      // T5: CLR at F0, tick due at F4; CLR+RUN again exactly at F4 wins.
      bus_write(4'd5, 32'h3, 4'hF);
      repeat (3) @(negedge clock);
      bus_write(4'd5, 32'h3, 4'hF);
      bus_read(4'd2, 32'd0, "t5_clr_wins");
      bus_read(4'd5, 32'h2, "t5_ctrl");
      bus_read(4'd2, 32'd0, "t5_pre_tick");
      bus_read(4'd2, 32'd0, "t5_tick_cycle");
      bus_read(4'd2, 32'd1, "t5_after_tick");

      // T4: preload counter just below a 32-bit carry, tick on the lo read.
      bus_write(4'd5, 32'h0, 4'hF);
      force dut.cnt_q   = 64'h0000_0001_FFFF_FFFF;
      force dut.presc_q = 16'd3;
      @(negedge clock);
      release dut.cnt_q;
      release dut.presc_q;
      bus_write(4'd5, 32'h2, 4'hF);
      bus_read(4'd2, 32'hFFFF_FFFF, "t4_lo");
      bus_read(4'd3, 32'h1,         "t4_hi");
      bus_read(4'd3, 32'h1,         "t4_hi_again");
      bus_read(4'd2, 32'h0,         "t4_lo2");
      bus_read(4'd3, 32'h2,         "t4_hi2");

      // Full-width wrap: all ones ticks to zero.
      bus_write(4'd5, 32'h0, 4'hF);
      force dut.cnt_q   = 64'hFFFF_FFFF_FFFF_FFFF;
      force dut.presc_q = 16'd3;
      @(negedge clock);
      release dut.cnt_q;
      release dut.presc_q;
      bus_write(4'd5, 32'h2, 4'hF);
      bus_read(4'd2, 32'hFFFF_FFFF, "wrap_lo");
      bus_read(4'd3, 32'hFFFF_FFFF, "wrap_hi");
      bus_read(4'd2, 32'h0,         "wrap_lo_zero");
      bus_read(4'd3, 32'h0,         "wrap_hi_zero");
`else
      // Build without uptime: words 2, 3, 5 read 0; CTRL writes ignored.
      bus_read(4'd2, 32'h0, "noup_lo");
      bus_read(4'd3, 32'h0, "noup_hi");
      bus_write(4'd5, 32'h3, 4'hF);
      repeat (8) @(negedge clock);
      bus_read(4'd5, 32'h0, "noup_ctrl");
      bus_read(4'd2, 32'h0, "noup_lo_after");
`endif

      // T6: reset asserted in the cycle after a read; the read is lost.
      sbus.address = 4'd0;
      sbus.read    = 1'b1;
      @(posedge clock);
      #1;
      reset_n   = 1'b0;
      sbus.read = 1'b0;
      #1;
      check("t6_rdvalid_drop", {31'd0, sbus.readdatavalid}, 32'h0);
      check("t6_readdata_rst", sbus.readdata, 32'h0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      bus_read(4'd4, 32'h0,    "t6_scratch_rst");
      bus_read(4'd5, CTRL_RST, "t6_ctrl_rst");
      bus_read(4'd1, TS_EXP,   "t6_ts");

      repeat (3) @(negedge clock);
      check("drain", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
